// File: rtl/cic_pkg.sv
// Shared constants and width helpers for the multi-channel CIC decimator.
package cic_pkg;

   localparam int unsigned MODE_FULL  = 0;
   localparam int unsigned MODE_ROUND = 1;

   localparam int unsigned WIN_DEF  = 16;
   localparam int unsigned N_DEF    = 3;
   localparam int unsigned RMAX_DEF = 2048;
   localparam int unsigned NCH_DEF  = 4;
   localparam int unsigned WOUT_DEF = 24;

   function automatic int unsigned cic_clog2(input int unsigned v);
      int unsigned      r;
      longint unsigned  p;
      r = 0;
      p = 1;
      while (p < 64'(v)) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

   // Channel tag width: at least one bit even for a single channel.
   function automatic int unsigned cic_chw(input int unsigned nch);
      return (cic_clog2(nch) > 0) ? cic_clog2(nch) : 1;
   endfunction

   function automatic int unsigned cic_wi(input int unsigned win, input int unsigned n,
                                          input int unsigned rmax);
      return win + n * cic_clog2(rmax);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb stage: y = x - x_prev[ch], with a per-channel delay register.
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter  int unsigned W   = 49,
   parameter  int unsigned NCH = 4,
   localparam int unsigned CHW = cic_chw(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           in_v,
   input  logic [CHW-1:0] in_ch,
   input  logic [W-1:0]   in_data,
   output logic           out_v,
   output logic [CHW-1:0] out_ch,
   output logic [W-1:0]   out_data
);

   logic [W-1:0] prev [NCH];

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         out_v    <= 1'b0;
         out_ch   <= '0;
         out_data <= '0;
         for (int c = 0; c < int'(NCH); c++) prev[c] <= '0;
      end else begin
         out_v <= in_v;
         if (in_v) begin
            out_ch        <= in_ch;
            out_data      <= in_data - prev[in_ch];
            prev[in_ch]   <= in_data;
         end
      end
   end

endmodule

// File: rtl/cic_dec_mc.sv
// Multi-channel CIC decimator: per-channel integrators, frame-based decimation,
// shared N-stage comb pipeline and optional round/saturate output.
module cic_dec_mc
   import cic_pkg::*;
#(
   parameter  int unsigned Win  = WIN_DEF,
   parameter  int unsigned N    = N_DEF,
   parameter  int unsigned RMAX = RMAX_DEF,
   parameter  int unsigned NCH  = NCH_DEF,
   parameter  int unsigned WOUT = WOUT_DEF,
   parameter  int unsigned MODE = MODE_FULL,
   localparam int unsigned RW   = cic_clog2(RMAX + 1),
   localparam int unsigned WI   = cic_wi(Win, N, RMAX),
   localparam int unsigned CHW  = cic_chw(NCH),
   localparam int unsigned WO   = (MODE == MODE_ROUND) ? WOUT : WI
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [Win-1:0] i_data,
   input  logic [CHW-1:0]        i_ch,
   input  logic                  val_in,
   input  logic [RW-1:0]         r_cfg,
   input  logic                  r_load,
   output logic signed [WO-1:0]  o_data,
   output logic [CHW-1:0]        o_ch,
   output logic                  val_out,
   output logic                  ch_err
);

   logic [RW-1:0]  r_reg, dcnt, r_clamped;
   logic [WI-1:0]  integ [NCH][N];
   logic [WI-1:0]  integ_nxt [N];
   logic           tag_ok, accept, frame_end, dec_phase;
   logic [CHW-1:0] ch_sel;

   logic           d0_v;
   logic [CHW-1:0] d0_ch;
   logic [WI-1:0]  d0_data;

   logic           c_v  [N+1];
   logic [CHW-1:0] c_ch [N+1];
   logic [WI-1:0]  c_d  [N+1];

   logic           r_v;
   logic [CHW-1:0] r_ch;
   logic [WO-1:0]  r_data, rnd;

   assign tag_ok    = 32'(i_ch) < NCH;
   assign accept    = val_in && !r_load && tag_ok;
   assign ch_sel    = tag_ok ? i_ch : '0;
   assign frame_end = 32'(i_ch) == (NCH - 1);
   assign dec_phase = dcnt == (r_reg - RW'(1));

   always_comb begin
      r_clamped = r_cfg;
      if (32'(r_cfg) < 2)         r_clamped = RW'(2);
      else if (32'(r_cfg) > RMAX) r_clamped = RW'(RMAX);
   end

   // Integrator chain of the addressed channel, all N adders in one cycle.
   always_comb begin
      logic [WI-1:0] acc;
      acc = WI'(i_data);
      for (int k = 0; k < int'(N); k++) begin
         acc          = integ[ch_sel][k] + acc;
         integ_nxt[k] = acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || r_load) begin
         r_reg   <= rst ? RW'(RMAX) : r_clamped;
         dcnt    <= '0;
         d0_v    <= 1'b0;
         d0_ch   <= '0;
         d0_data <= '0;
         for (int c = 0; c < int'(NCH); c++)
            for (int k = 0; k < int'(N); k++) integ[c][k] <= '0;
      end else begin
         d0_v <= accept && dec_phase;
         if (accept) begin
            d0_ch   <= i_ch;
            d0_data <= integ_nxt[N-1];
            for (int k = 0; k < int'(N); k++) integ[ch_sel][k] <= integ_nxt[k];
            if (frame_end) dcnt <= dec_phase ? '0 : dcnt + RW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ch_err <= 1'b0;
      else     ch_err <= val_in && !r_load && !tag_ok;
   end

   assign c_v[0]  = d0_v;
   assign c_ch[0] = d0_ch;
   assign c_d[0]  = d0_data;

   for (genvar k = 0; k < int'(N); k++) begin : g_comb
      cic_comb_stage #(.W(WI), .NCH(NCH)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .clr      (r_load),
         .in_v     (c_v[k]),
         .in_ch    (c_ch[k]),
         .in_data  (c_d[k]),
         .out_v    (c_v[k+1]),
         .out_ch   (c_ch[k+1]),
         .out_data (c_d[k+1])
      );
   end

   if (MODE == MODE_ROUND) begin : g_round
      localparam int unsigned S = WI - WOUT;
      localparam logic signed [WI:0] HI = (WI+1)'((longint'(1) << (WOUT - 1)) - longint'(1));
      localparam logic signed [WI:0] LO = ~HI;
      logic signed [WI:0] biased, shifted;
      always_comb begin
         biased  = $signed((WI+1)'($signed(c_d[N]))) + $signed((WI+1)'(1) << (S - 1));
         shifted = biased >>> S;
         if (shifted > HI)      rnd = WO'(HI);
         else if (shifted < LO) rnd = WO'(LO);
         else                   rnd = WO'(shifted);
      end
   end else begin : g_full
      assign rnd = c_d[N];
   end

   // Round/saturate register followed by the output register.
   always_ff @(posedge clk) begin
      if (rst || r_load) begin
         r_v     <= 1'b0;
         r_ch    <= '0;
         r_data  <= '0;
         val_out <= 1'b0;
         o_ch    <= '0;
         o_data  <= '0;
      end else begin
         r_v     <= c_v[N];
         val_out <= r_v;
         if (c_v[N]) begin
            r_ch   <= c_ch[N];
            r_data <= rnd;
         end
         if (r_v) begin
            o_ch   <= r_ch;
            o_data <= r_data;
         end
      end
   end

endmodule

// File: tb/tb_cic_dec_mc.sv
// Bench for cic_dec_mc: a full-width 4-channel instance and a rounding 3-channel instance.
module tb_cic_dec_mc;

   logic clk, rst;
   logic v0, rl0, vo0, er0;
   logic [1:0] c0, oc0;
   logic signed [15:0] x0;
   logic [11:0] rc0;
   logic signed [48:0] od0;
   logic v1, rl1, vo1, er1;
   logic [1:0] c1, oc1;
   logic signed [15:0] x1;
   logic [4:0] rc1;
   logic signed [15:0] od1;

   cic_dec_mc dut0 (
      .clk(clk), .rst(rst), .i_data(x0), .i_ch(c0), .val_in(v0), .r_cfg(rc0),
      .r_load(rl0), .o_data(od0), .o_ch(oc0), .val_out(vo0), .ch_err(er0));

   cic_dec_mc #(.Win(16), .N(3), .RMAX(16), .NCH(3), .WOUT(16), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .i_data(x1), .i_ch(c1), .val_in(v1), .r_cfg(rc1),
      .r_load(rl1), .o_data(od1), .o_ch(oc1), .val_out(vo1), .ch_err(er1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int due; int ch; longint data; } exp_t;
   exp_t q0[$], q1[$];
   int     lc0[$], lc1[$];
   longint ld0[$], ld1[$];

   longint unsigned m_int  [2][4][3];
   longint unsigned m_prev [2][4][3];
   int m_dcnt [2], m_r [2], err_due [2];
   int n_tests = 0, n_fail = 0, err_cnt1 = 0;

   function automatic int wi(int d);   return (d == 0) ? 49 : 28;   endfunction
   function automatic int nch(int d);  return (d == 0) ? 4 : 3;     endfunction
   function automatic int rmax(int d); return (d == 0) ? 2048 : 16; endfunction

   task automatic chk(string name, longint act, longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear(int d);
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 3; k++) begin
            m_int[d][c][k]  = 0;
            m_prev[d][c][k] = 0;
         end
      m_dcnt[d] = 0;
   endtask

   task automatic flush(int d, int e);
      if (d == 0) while (q0.size() > 0 && q0[$].due >= e) void'(q0.pop_back());
      else        while (q1.size() > 0 && q1[$].due >= e) void'(q1.pop_back());
   endtask

   // Full-width value as signed, or rounded-half-up and saturated to 16 bits.
   function automatic longint shape(int d, longint unsigned y);
      longint unsigned m;
      longint s, t;
      m = (64'd1 << wi(d)) - 1;
      s = ((y >> (wi(d) - 1)) & 1) != 0 ? longint'(y | ~m) : longint'(y);
      if (d == 0) return s;
      t = (s + (longint'(1) << 11)) >>> 12;
      if (t > 32767)  t = 32767;
      if (t < -32768) t = -32768;
      return t;
   endfunction

   task automatic model_sample(int d, int ch, longint x, int e);
      longint unsigned m, acc, y, t;
      exp_t it;
      m   = (64'd1 << wi(d)) - 1;
      acc = longint'(x) & m;
      for (int k = 0; k < 3; k++) begin
         m_int[d][ch][k] = (m_int[d][ch][k] + acc) & m;
         acc = m_int[d][ch][k];
      end
      if (m_dcnt[d] == m_r[d] - 1) begin
         y = acc;
         for (int k = 0; k < 3; k++) begin
            t = (y - m_prev[d][ch][k]) & m;
            m_prev[d][ch][k] = y;
            y = t;
         end
         it.due = e + 5; it.ch = ch; it.data = shape(d, y);
         if (d == 0) q0.push_back(it); else q1.push_back(it);
      end
      if (ch == nch(d) - 1) m_dcnt[d] = (m_dcnt[d] == m_r[d] - 1) ? 0 : m_dcnt[d] + 1;
   endtask

   // One clock of stimulus on instance d; the other instance idles.
   task automatic drive(int d, bit v, int ch, longint x, bit load, int rcfg);
      int e;
      e = cyc + 1;
      if (d == 0) begin
         v0 = v; c0 = 2'(ch); x0 = 16'(x); rl0 = load; rc0 = 12'(rcfg); v1 = 0; rl1 = 0;
      end else begin
         v1 = v; c1 = 2'(ch); x1 = 16'(x); rl1 = load; rc1 = 5'(rcfg); v0 = 0; rl0 = 0;
      end
      if (load) begin
         flush(d, e);
         model_clear(d);
         m_r[d] = (rcfg < 2) ? 2 : ((rcfg > rmax(d)) ? rmax(d) : rcfg);
      end else if (v) begin
         if (ch >= nch(d)) err_due[d] = e;
         else model_sample(d, ch, x, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic frame(int d, longint x);
      for (int c = 0; c < nch(d); c++) drive(d, 1, c, x, 0, 0);
   endtask

   task automatic pulse_rst();
      int e;
      e = cyc + 1;
      rst = 1; v0 = 0; v1 = 0; rl0 = 0; rl1 = 0;
      for (int d = 0; d < 2; d++) begin
         flush(d, e); model_clear(d); m_r[d] = rmax(d); err_due[d] = -1;
      end
      @(posedge clk); #1;
      rst = 0;
      chk("rst_val_out", longint'(vo0), 0);
      chk("rst_o_data", longint'(od0), 0);
      chk("rst_o_ch", longint'(oc0), 0);
   endtask

   function automatic longint nth(int d, int c, int k);
      int n;
      n = 0;
      if (d == 0) begin
         foreach (lc0[i]) if (lc0[i] == c) begin if (n == k) return ld0[i]; n++; end
      end else begin
         foreach (lc1[i]) if (lc1[i] == c) begin if (n == k) return ld1[i]; n++; end
      end
      return 64'sh7fff_ffff_ffff_ffff;
   endfunction

   function automatic int cnt(int d, int c);
      int n;
      n = 0;
      if (d == 0) begin foreach (lc0[i]) if (lc0[i] == c) n++; end
      else        begin foreach (lc1[i]) if (lc1[i] == c) n++; end
      return n;
   endfunction

   task automatic check_out(int d, bit v, int ch, longint data, bit err);
      bit ev, ee;
      exp_t h;
      ev = 0;
      if (d == 0) begin
         if (q0.size() > 0 && q0[0].due == cyc) begin ev = 1; h = q0.pop_front(); end
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) begin ev = 1; h = q1.pop_front(); end
      end
      if (ev || v) begin
         chk(d == 0 ? "val_out0" : "val_out1", longint'(v), longint'(ev));
         if (ev && v) begin
            chk(d == 0 ? "o_ch0" : "o_ch1", ch, h.ch);
            chk(d == 0 ? "o_data0" : "o_data1", data, h.data);
         end
         if (v) begin
            if (d == 0) begin lc0.push_back(ch); ld0.push_back(data); end
            else        begin lc1.push_back(ch); ld1.push_back(data); end
         end
      end
      ee = (err_due[d] == cyc);
      if (ee || err) chk(d == 0 ? "ch_err0" : "ch_err1", longint'(err), longint'(ee));
      if (d == 1 && err) err_cnt1++;
   endtask

   always @(negedge clk) begin
      check_out(0, vo0, int'(oc0), longint'(od0), er0);
      check_out(1, vo1, int'(oc1), longint'(od1), er1);
   end

   initial begin
      rst = 1; v0 = 0; rl0 = 0; c0 = 0; x0 = 0; rc0 = 0;
      v1 = 0; rl1 = 0; c1 = 0; x1 = 0; rc1 = 0;
      for (int d = 0; d < 2; d++) begin
         model_clear(d); m_r[d] = rmax(d); err_due[d] = -1;
      end
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("reset_o_data0", longint'(od0), 0);
      chk("reset_o_ch0", longint'(oc0), 0);
      chk("reset_val_out0", longint'(vo0), 0);
      chk("reset_ch_err0", longint'(er0), 0);
      chk("reset_o_data1", longint'(od1), 0);

      // DC 1 on all channels, R=4: 20, 60, then R^N = 64
      drive(0, 0, 0, 0, 1, 4);
      lc0.delete(); ld0.delete();
      repeat (16) frame(0, 1);
      idle(8);
      chk("dc_first", nth(0, 2, 0), 20);
      chk("dc_second", nth(0, 0, 1), 60);
      chk("dc_steady", nth(0, 3, 3), 64);

      // Impulse 1000 on ch2, R=4: polyphase taps 10, 6, 0
      drive(0, 0, 0, 0, 1, 4);
      lc0.delete(); ld0.delete();
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0);
      drive(0, 1, 2, 1000, 0, 0);
      drive(0, 1, 3, 0, 0, 0);
      repeat (11) frame(0, 0);
      idle(8);
      chk("imp_0", nth(0, 2, 0), 10000);
      chk("imp_1", nth(0, 2, 1), 6000);
      chk("imp_2", nth(0, 2, 2), 0);
      chk("imp_other", nth(0, 1, 1), 0);

      // Reload mid-stream to R=8 (sample in the load cycle is dropped), then R=1 -> 2
      drive(0, 0, 0, 0, 1, 4);
      repeat (6) frame(0, 1);
      drive(0, 1, 0, 1, 1, 8);
      lc0.delete(); ld0.delete();
      repeat (32) frame(0, 1);
      idle(8);
      chk("r8_count", cnt(0, 0), 4);
      chk("r8_first", nth(0, 1, 0), 120);
      chk("r8_steady", nth(0, 0, 2), 512);
      drive(0, 0, 0, 0, 1, 1);
      lc0.delete(); ld0.delete();
      repeat (8) frame(0, 1);
      idle(8);
      chk("r2_count", cnt(0, 0), 4);
      chk("r2_steady", nth(0, 3, 1), 8);

      // Reset with a decimated frame still in the comb pipeline
      drive(0, 0, 0, 0, 1, 4);
      repeat (4) frame(0, 1);
      pulse_rst();
      lc0.delete(); ld0.delete();
      idle(10);
      chk("rst_quiet", lc0.size(), 0);
      drive(0, 0, 0, 0, 1, 2);
      repeat (2) frame(0, 1);
      idle(8);
      chk("post_rst_count", cnt(0, 0), 1);
      chk("post_rst_val", nth(0, 0, 0), 4);

      // Random out-of-order channels with idle gaps, R=5
      drive(0, 0, 0, 0, 1, 5);
      repeat (160) begin
         drive(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
               longint'($signed(16'($urandom))), 0, 0);
      end
      idle(8);

      // Rounding instance: +full-scale DC with one invalid tag mid-stream
      drive(1, 0, 0, 0, 1, 16);
      lc1.delete(); ld1.delete();
      repeat (40) frame(1, 32767);
      drive(1, 1, 3, 5, 0, 0);
      repeat (40) frame(1, 32767);
      idle(8);
      chk("sat_pos", nth(1, 0, 4), 32767);
      chk("ch_err_count", err_cnt1, 1);
      // -full-scale DC, r_cfg=31 clamps to RMAX=16
      drive(1, 0, 0, 0, 1, 31);
      lc1.delete(); ld1.delete();
      repeat (80) frame(1, -32768);
      idle(8);
      chk("sat_neg", nth(1, 2, 4), -32768);
      chk("clamp_count", cnt(1, 2), 5);

      idle(4);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
